inst_fetch: RTL and testbench

Instruction fetch unit between the PC generator and the decode stage. It takes the current fetch address and fetch-suppress flag from the PC generator and issues one request at a time to instruction memory over a valid/ready request and valid response interface. Returned words are queued with their PC toward decode. It drives the PC generator's stall input and discards in-flight fetches when a branch redirect flushes the front end.

---
 rtl/inst_fetch_if.sv | 28 ++
 rtl/inst_fetch.sv | 155 +++++++++++++++
 tb/tb_inst_fetch.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave):
// valid/ready request channel plus a valid-only response channel.
interface inst_fetch_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) ();
    logic              imem_req_valid;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding imem request at a time, fetched words queued toward ID.
// Define ysyx22040228_FETCH_BUF2_EN for a two-entry buffer; otherwise a single output register.
module inst_fetch #(
    parameter int                PC_W     = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              pc_ce_i,
    input  logic              flush_i,
    output logic              pc_stall_o,
    inst_fetch_if.master      imem,
    output logic              if_valid_o,
    output logic [PC_W-1:0]   if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_misalign_o,
    input  logic              if_ready_i
);

`ifdef ysyx22040228_FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              misalign;
    } entry_t;

    state_e          state_q, state_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            drop_pending_q, drop_pending_d;
    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [1:0]      count_q, count_d;
    logic            issue;
    logic            push;
    logic            pop;
    entry_t          push_entry;
    int              wr_idx;

    // The buffer slot is reserved at issue time, so a later push always has room.
    assign issue      = (state_q == IDLE) && !pc_ce_i && !flush_i && (count_q < DEPTH_C);
    assign pc_stall_o = !issue;
    assign pop        = (count_q != 2'd0) && if_ready_i;

    assign imem.imem_req_valid = (state_q == REQ);
    assign imem.imem_req_addr  = req_pc_q;

    assign if_valid_o    = (count_q != 2'd0);
    assign if_pc_o       = fifo_q[0].pc;
    assign if_inst_o     = fifo_q[0].inst;
    assign if_misalign_o = fifo_q[0].misalign;

    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        drop_pending_d = drop_pending_q;
        push           = 1'b0;
        push_entry     = '0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    if (pc_i[1:0] == 2'b00) begin
                        req_pc_d       = pc_i;
                        drop_pending_d = 1'b0;
                        state_d        = REQ;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_i, inst: NOP_INST, misalign: 1'b1};
                    end
                end
            end
            REQ: begin
                // A request already on the bus cannot be withdrawn; remember to discard its reply.
                if (flush_i) begin
                    drop_pending_d = 1'b1;
                end
                if (imem.imem_req_ready) begin
                    state_d        = (drop_pending_q || flush_i) ? DROP : WAIT;
                    drop_pending_d = 1'b0;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d    = IDLE;
                    push       = !flush_i;
                    push_entry = '{pc: req_pc_q, inst: imem.imem_rsp_data, misalign: 1'b0};
                end else if (flush_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem.imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        wr_idx  = int'(count_q) - (pop ? 1 : 0);
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == wr_idx) begin
                        fifo_d[i] = push_entry;
                    end
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            req_pc_q       <= '0;
            drop_pending_q <= 1'b0;
            count_q        <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            req_pc_q       <= req_pc_d;
            drop_pending_q <= drop_pending_d;
            count_q        <= count_d;
            fifo_q         <= fifo_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic checked every cycle against
// a transaction-level model (fetch queue + outstanding-request flags) that also plays the memory.
module tb_inst_fetch;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
`ifdef ysyx22040228_FETCH_BUF2_EN
    localparam int MDEPTH = 2;
`else
    localparam int MDEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   pc_i;
    logic              pc_ce_i;
    logic              flush_i;
    logic              pc_stall_o;
    logic              if_valid_o;
    logic [PC_W-1:0]   if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              if_misalign_o;
    logic              if_ready_i;

    always #5 clk = ~clk;

    inst_fetch_if #(.PC_W(PC_W), .INST_W(INST_W)) imem ();

    inst_fetch #(.PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_ce_i      (pc_ce_i),
        .flush_i      (flush_i),
        .pc_stall_o   (pc_stall_o),
        .imem         (imem),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_misalign_o(if_misalign_o),
        .if_ready_i   (if_ready_i)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          mis;
    } fetch_t;

    fetch_t      mQ[$];
    bit          mReqOut;
    bit          mInFlight;
    bit          mDoomed;
    bit          modelValid = 1'b0;
    logic [63:0] mAddr;
    int          mDelay;
    int          memMin = 0;
    int          memMax = 0;
    bit          noiseEn = 1'b0;
    bit          lastIssue;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0093;
        if (a == 64'h8000_0040) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelIssue();
        return !mReqOut && !mInFlight && !pc_ce_i && !flush_i && (mQ.size() < MDEPTH);
    endfunction

    task automatic checkAll();
        if (!modelValid) return;
        checkOutput("req_valid", 64'(imem.imem_req_valid), 64'(mReqOut));
        if (mReqOut) checkOutput("req_addr", imem.imem_req_addr, mAddr);
        checkOutput("if_valid", 64'(if_valid_o), 64'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            checkOutput("if_pc", if_pc_o, mQ[0].pc);
            checkOutput("if_inst", 64'(if_inst_o), 64'(mQ[0].inst));
            checkOutput("if_misalign", 64'(if_misalign_o), 64'(mQ[0].mis));
        end
        checkOutput("pc_stall", 64'(pc_stall_o), 64'(!modelIssue()));
    endtask

    task automatic modelStep();
        bit     issue;
        bit     pop;
        bit     push;
        fetch_t e;
        if (rst) begin
            mQ.delete();
            mReqOut    = 1'b0;
            mInFlight  = 1'b0;
            mDoomed    = 1'b0;
            mAddr      = '0;
            lastIssue  = 1'b0;
            modelValid = 1'b1;
            return;
        end
        issue     = modelIssue();
        pop       = (mQ.size() != 0) && if_ready_i;
        push      = 1'b0;
        e         = '{pc: '0, inst: '0, mis: 1'b0};
        lastIssue = issue;
        if (mReqOut) begin
            if (flush_i) mDoomed = 1'b1;
            if (imem.imem_req_ready) begin
                mReqOut   = 1'b0;
                mInFlight = 1'b1;
                mDelay    = int'($urandom_range(memMax, memMin));
            end
        end else if (mInFlight) begin
            if (imem.imem_rsp_valid) begin
                mInFlight = 1'b0;
                if (!mDoomed && !flush_i) begin
                    push = 1'b1;
                    e    = '{pc: mAddr, inst: imem.imem_rsp_data, mis: 1'b0};
                end
                mDoomed = 1'b0;
            end else begin
                if (flush_i) mDoomed = 1'b1;
                if (mDelay > 0) mDelay--;
            end
        end else if (issue) begin
            if (pc_i[1:0] == 2'b00) begin
                mReqOut = 1'b1;
                mAddr   = pc_i;
                mDoomed = 1'b0;
            end else begin
                push = 1'b1;
                e    = '{pc: pc_i, inst: 32'h0000_0013, mis: 1'b1};
            end
        end
        if (flush_i) begin
            mQ.delete();
        end else begin
            if (pop) void'(mQ.pop_front());
            if (push) mQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ce, input bit fl, input logic [63:0] pcv,
                                 input bit rdy, input bit irdy);
        @(negedge clk);
        rst                 = r;
        pc_ce_i             = ce;
        flush_i             = fl;
        pc_i                = pcv;
        imem.imem_req_ready = rdy;
        if_ready_i          = irdy;
        if (!r && modelValid && mInFlight && mDelay == 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = memWord(mAddr);
        end else if (!r && modelValid && !mInFlight && noiseEn && $urandom_range(9) == 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = $urandom;
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
        end
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        logic [63:0] pcReg;
        logic [63:0] tgt;
        bit          r;
        bit          fl;
        bit          ce;

        rst                 = 1'b1;
        pc_ce_i             = 1'b1;
        flush_i             = 1'b0;
        pc_i                = '0;
        if_ready_i          = 1'b0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;

        applyStimulus(1, 1, 0, 64'h0, 0, 1);
        applyStimulus(1, 1, 0, 64'h0, 0, 1);
        #1;
        checkOutput("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
        checkOutput("rst_req_addr", imem.imem_req_addr, 64'd0);
        checkOutput("rst_if_valid", 64'(if_valid_o), 64'd0);
        checkOutput("rst_if_pc", if_pc_o, 64'd0);
        checkOutput("rst_if_inst", 64'(if_inst_o), 64'd0);
        checkOutput("rst_if_misalign", 64'(if_misalign_o), 64'd0);
        checkOutput("rst_pc_stall", 64'(pc_stall_o), 64'd1);

        // Zero-wait fetch: capture, accept, respond, then visible at ID.
        applyStimulus(0, 0, 0, 64'h8000_0000, 1, 1);
        #1;
        checkOutput("zw_req_valid", 64'(imem.imem_req_valid), 64'd1);
        checkOutput("zw_req_addr", imem.imem_req_addr, 64'h8000_0000);
        checkOutput("zw_stall_req", 64'(pc_stall_o), 64'd1);
        applyStimulus(0, 0, 0, 64'h8000_0004, 1, 1);
        applyStimulus(0, 0, 0, 64'h8000_0004, 1, 1);
        #1;
        checkOutput("zw_if_valid", 64'(if_valid_o), 64'd1);
        checkOutput("zw_if_pc", if_pc_o, 64'h8000_0000);
        checkOutput("zw_if_inst", 64'(if_inst_o), 64'h0000_0093);
        checkOutput("zw_if_misalign", 64'(if_misalign_o), 64'd0);
        repeat (3) applyStimulus(0, 1, 0, 64'h8000_0004, 1, 1);

        // Request held while memory is not ready.
        applyStimulus(0, 0, 0, 64'h8000_0004, 0, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("hold_req_valid", 64'(imem.imem_req_valid), 64'd1);
            checkOutput("hold_req_addr", imem.imem_req_addr, 64'h8000_0004);
            checkOutput("hold_pc_stall", 64'(pc_stall_o), 64'd1);
            applyStimulus(0, 0, 0, 64'h8000_0008, k == 4, 1);
        end
        repeat (3) applyStimulus(0, 1, 0, 64'h8000_0008, 1, 1);

        // Flush while waiting for the response: the late word must be discarded.
        memMin = 2;
        memMax = 2;
        applyStimulus(0, 0, 0, 64'h8000_0040, 1, 1);
        applyStimulus(0, 0, 0, 64'h8000_0044, 1, 1);
        applyStimulus(0, 0, 1, 64'h8000_0044, 1, 1);
        #1;
        checkOutput("flush_if_valid", 64'(if_valid_o), 64'd0);
        applyStimulus(0, 0, 0, 64'h8000_0100, 1, 1);
        applyStimulus(0, 0, 0, 64'h8000_0100, 1, 1);
        #1;
        checkOutput("drop_if_valid", 64'(if_valid_o), 64'd0);
        checkOutput("drop_pc_stall", 64'(pc_stall_o), 64'd0);
        memMin = 0;
        memMax = 0;
        applyStimulus(0, 0, 0, 64'h8000_0100, 1, 1);
        #1;
        checkOutput("redir_req_valid", 64'(imem.imem_req_valid), 64'd1);
        checkOutput("redir_req_addr", imem.imem_req_addr, 64'h8000_0100);
        checkOutput("redir_if_valid", 64'(if_valid_o), 64'd0);
        repeat (3) applyStimulus(0, 1, 0, 64'h8000_0104, 1, 1);

        // Misaligned PC yields a NOP entry without touching memory.
        applyStimulus(0, 0, 0, 64'h8000_0002, 1, 0);
        #1;
        checkOutput("mis_req_valid", 64'(imem.imem_req_valid), 64'd0);
        checkOutput("mis_if_valid", 64'(if_valid_o), 64'd1);
        checkOutput("mis_if_pc", if_pc_o, 64'h8000_0002);
        checkOutput("mis_if_inst", 64'(if_inst_o), 64'h0000_0013);
        checkOutput("mis_if_misalign", 64'(if_misalign_o), 64'd1);
        repeat (2) applyStimulus(0, 1, 0, 64'h8000_0006, 1, 1);

        // ID stalled: buffer fills to its depth, then drains in order.
        pcReg = 64'h8000_0200;
        repeat (12) begin
            applyStimulus(0, 0, 0, pcReg, 1, 0);
            if (lastIssue) pcReg += 64'd4;
        end
        #1;
        checkOutput("bp_pc_stall", 64'(pc_stall_o), 64'd1);
        checkOutput("bp_req_valid", 64'(imem.imem_req_valid), 64'd0);
        checkOutput("bp_if_valid", 64'(if_valid_o), 64'd1);
        checkOutput("bp_if_pc", if_pc_o, 64'h8000_0200);
        checkOutput("bp_next_pc", pcReg, 64'h8000_0200 + 64'(4 * MDEPTH));
        applyStimulus(0, 1, 0, pcReg, 1, 1);
        #1;
        checkOutput("bp_second_valid", 64'(if_valid_o), 64'(MDEPTH > 1));
        applyStimulus(0, 1, 0, pcReg, 1, 1);
        #1;
        checkOutput("bp_drained", 64'(if_valid_o), 64'd0);

        // Reset while a request is on the bus.
        applyStimulus(0, 0, 0, 64'h8000_0300, 0, 1);
        applyStimulus(1, 1, 0, 64'h8000_0300, 0, 1);
        #1;
        checkOutput("rreq_req_valid", 64'(imem.imem_req_valid), 64'd0);
        checkOutput("rreq_if_valid", 64'(if_valid_o), 64'd0);
        checkOutput("rreq_pc_stall", 64'(pc_stall_o), 64'd1);
        applyStimulus(0, 0, 0, 64'h8000_0300, 1, 1);

        // Randomized traffic with variable memory latency and stray response pulses.
        noiseEn = 1'b1;
        memMin  = 0;
        memMax  = 3;
        pcReg   = 64'h8000_0000;
        repeat (3000) begin
            r   = ($urandom_range(199) == 0);
            fl  = !r && ($urandom_range(15) == 0);
            ce  = r || ($urandom_range(9) == 0);
            tgt = 64'h8000_0000 + 64'($urandom_range(255)) * 64'd4
                  + (($urandom_range(6) == 0) ? 64'd2 : 64'd0);
            applyStimulus(r, ce, fl, pcReg, $urandom_range(9) < 7, $urandom_range(9) < 6);
            if (r) pcReg = 64'h8000_0000;
            else if (fl) pcReg = tgt;
            else if (lastIssue) pcReg += 64'd4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
